vectored_int_ctrl: RTL and testbench

- Parametrised multi-source interrupt controller; replaces the single-wire intr/int_ack path between the IO module and the CPU's MCU.
- Synchronises NUM_IRQ external request lines and latches them as pending. Mode is edge or level.
- Applies a software mask and raises one intr to the MCU. On int_ack it captures the highest-priority source ID into a vector register.
- Holds off further interrupts until software writes EOI through the memory-mapped IO port.

---
 rtl/vectored_int_ctrl.sv | 130 +++++++++++++
 tb/tb_vectored_int_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vectored_int_ctrl.sv
// rtl/vectored_int_ctrl.sv - multi-source vectored interrupt controller with mask, priority and EOI handshake
module vectored_int_ctrl #(
    parameter int NUM_IRQ   = 8,
    parameter int ID_W      = 3,
    parameter int EDGE_MODE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               int_ack,
    output logic               intr,
    input  logic               io_cs,
    input  logic               io_wr,
    input  logic               io_rd,
    input  logic [1:0]         addr,
    input  logic [31:0]        D_IN,
    output logic [31:0]        D_OUT,
    output logic [ID_W-1:0]    vec_id,
    output logic               in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] s1, s2, s3;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] win_onehot;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [ID_W-1:0]    winner;
    logic [31:0]        rd_data;
    logic               wr_mask, wr_clear, eoi, ack_take;
    logic               unused_d_in;

    assign unused_d_in = ^D_IN;

    assign wr_mask  = io_cs & io_wr & (addr == 2'd1);
    assign wr_clear = io_cs & io_wr & (addr == 2'd2);
    assign eoi      = io_cs & io_wr & (addr == 2'd3);

    // Level mode tracks the synchronised line directly; the latch is only used in edge mode.
    assign pending    = (EDGE_MODE != 0) ? pend_q : s2;
    assign active     = pending & mask;
    assign win_onehot = active & (~active + NUM_IRQ'(1));
    assign ack_take   = (state == REQ) && (active != '0) && int_ack;
    assign rise       = s2 & ~s3;
    assign clr        = (wr_clear ? D_IN[NUM_IRQ-1:0] : '0) | (ack_take ? win_onehot : '0);

    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) winner = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            pend_q <= '0;
            mask   <= '0;
        end else begin
            s1     <= irq;
            s2     <= s1;
            s3     <= s2;
            // A fresh edge beats any clear landing on the same cycle.
            pend_q <= rise | (pend_q & ~clr);
            if (wr_mask) mask <= D_IN[NUM_IRQ-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            intr       <= 1'b0;
            vec_id     <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (active != '0) begin
                        state <= REQ;
                        intr  <= 1'b1;
                    end
                end
                REQ: begin
                    if (active == '0) begin
                        state <= IDLE;
                        intr  <= 1'b0;
                    end else if (int_ack) begin
                        state      <= SERVICE;
                        vec_id     <= winner;
                        intr       <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    intr  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0: rd_data[NUM_IRQ-1:0] = pending;
            2'd1: rd_data[NUM_IRQ-1:0] = mask;
            2'd3: begin
                rd_data[31]       = in_service;
                rd_data[ID_W-1:0] = vec_id;
            end
            default: rd_data = '0;
        endcase
    end

    assign D_OUT = (io_cs && io_rd && !reset) ? rd_data : '0;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// tb/tb_vectored_int_ctrl.sv - directed self-checking bench for vectored_int_ctrl (edge and level instances)
module tb_vectored_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq, irq_l;
    logic        int_ack;
    logic        io_cs, io_wr, io_rd;
    logic [1:0]  addr;
    logic [31:0] d_in;
    logic        intr, intr_l;
    logic [31:0] d_out, d_out_l;
    logic [2:0]  vec_id, vec_id_l;
    logic        in_service, in_service_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vectored_int_ctrl #(.NUM_IRQ(8), .ID_W(3), .EDGE_MODE(1)) dut (
        .clk(clk), .reset(reset), .irq(irq), .int_ack(int_ack), .intr(intr),
        .io_cs(io_cs), .io_wr(io_wr), .io_rd(io_rd), .addr(addr),
        .D_IN(d_in), .D_OUT(d_out), .vec_id(vec_id), .in_service(in_service)
    );

    vectored_int_ctrl #(.NUM_IRQ(8), .ID_W(3), .EDGE_MODE(0)) dut_lvl (
        .clk(clk), .reset(reset), .irq(irq_l), .int_ack(int_ack), .intr(intr_l),
        .io_cs(io_cs), .io_wr(io_wr), .io_rd(io_rd), .addr(addr),
        .D_IN(d_in), .D_OUT(d_out_l), .vec_id(vec_id_l), .in_service(in_service_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        io_cs = 1'b1; io_wr = 1'b1; addr = a; d_in = d;
        tick();
        io_cs = 1'b0; io_wr = 1'b0; d_in = '0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input bit lvl, input logic [31:0] exp);
        io_cs = 1'b1; io_rd = 1'b1; addr = a;
        #1;
        check(tag, lvl ? d_out_l : d_out, exp);
        io_cs = 1'b0; io_rd = 1'b0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v);
        irq = v;
        tick();
        irq = '0;
    endtask

    initial begin
        reset = 1'b1; irq = '0; irq_l = '0; int_ack = 1'b0;
        io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0; addr = '0; d_in = '0;
        ticks(2);
        check("rst_intr", {31'd0, intr}, 32'd0);
        check("rst_vec", {29'd0, vec_id}, 32'd0);
        check("rst_insvc", {31'd0, in_service}, 32'd0);
        reset = 1'b0;
        tick();
        rd("rst_mask", 2'd1, 1'b0, 32'h0);
        rd("rst_pend", 2'd0, 1'b0, 32'h0);

        // 1: single source, latency and full ack/EOI cycle
        wr(2'd1, 32'h0000_00FF);
        pulse(8'h20);
        ticks(2);
        check("t1_intr_e3", {31'd0, intr}, 32'd0);
        tick();
        check("t1_intr_e4", {31'd0, intr}, 32'd1);
        ack();
        check("t1_vec", {29'd0, vec_id}, 32'd5);
        check("t1_insvc", {31'd0, in_service}, 32'd1);
        check("t1_intr_ack", {31'd0, intr}, 32'd0);
        rd("t1_pend", 2'd0, 1'b0, 32'h0);
        rd("t1_vecreg", 2'd3, 1'b0, 32'h8000_0005);
        wr(2'd3, 32'h0);
        check("t1_insvc_eoi", {31'd0, in_service}, 32'd0);
        tick();
        check("t1_intr_eoi", {31'd0, intr}, 32'd0);

        // 2: simultaneous sources, priority order
        pulse(8'h44);
        ticks(3);
        check("t2_intr", {31'd0, intr}, 32'd1);
        ack();
        check("t2_vec_a", {29'd0, vec_id}, 32'd2);
        rd("t2_pend", 2'd0, 1'b0, 32'h40);
        wr(2'd3, 32'h0);
        check("t2_intr_eoi", {31'd0, intr}, 32'd0);
        tick();
        check("t2_intr_re", {31'd0, intr}, 32'd1);
        ack();
        check("t2_vec_b", {29'd0, vec_id}, 32'd6);
        wr(2'd3, 32'h0);

        // register-port corners: write+read together, unused mask bits, CLEAR reads 0
        io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b1; addr = 2'd1; d_in = 32'hFFFF_FFF0;
        #1;
        check("rw_pre", d_out, 32'h0000_00FF);
        tick();
        io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
        rd("rw_post", 2'd1, 1'b0, 32'h0000_00F0);
        rd("clr_rd", 2'd2, 1'b0, 32'h0);

        // 3: masked pending, unmask, clear before ack
        wr(2'd1, 32'h0);
        pulse(8'h08);
        ticks(3);
        rd("t3_pend", 2'd0, 1'b0, 32'h08);
        check("t3_intr_masked", {31'd0, intr}, 32'd0);
        wr(2'd1, 32'h08);
        check("t3_intr_w", {31'd0, intr}, 32'd0);
        tick();
        check("t3_intr_unmask", {31'd0, intr}, 32'd1);
        wr(2'd2, 32'h08);
        tick();
        check("t3_intr_clr", {31'd0, intr}, 32'd0);
        rd("t3_pend_clr", 2'd0, 1'b0, 32'h0);

        // edge set and W1C on the same cycle: set wins
        wr(2'd1, 32'h0);
        pulse(8'h80);
        tick();
        wr(2'd2, 32'h80);
        rd("setwin_pend", 2'd0, 1'b0, 32'h80);
        wr(2'd2, 32'h80);
        rd("setwin_clr", 2'd0, 1'b0, 32'h0);
        wr(2'd1, 32'hFF);

        // 4: request during service is held until EOI
        pulse(8'h02);
        ticks(3);
        ack();
        check("t4_vec_a", {29'd0, vec_id}, 32'd1);
        pulse(8'h01);
        ticks(3);
        rd("t4_pend", 2'd0, 1'b0, 32'h01);
        check("t4_intr_svc", {31'd0, intr}, 32'd0);
        wr(2'd3, 32'h0);
        tick();
        check("t4_intr_re", {31'd0, intr}, 32'd1);
        ack();
        check("t4_vec_b", {29'd0, vec_id}, 32'd0);
        wr(2'd3, 32'h0);

        // 5: level mode instance
        irq_l = 8'h10;
        ticks(2);
        check("t5_intr_e2", {31'd0, intr_l}, 32'd0);
        tick();
        check("t5_intr_e3", {31'd0, intr_l}, 32'd1);
        ack();
        check("t5_vec", {29'd0, vec_id_l}, 32'd4);
        check("t5_insvc", {31'd0, in_service_l}, 32'd1);
        wr(2'd3, 32'h0);
        tick();
        check("t5_intr_re", {31'd0, intr_l}, 32'd1);
        wr(2'd2, 32'h10);
        rd("t5_pend_clr", 2'd0, 1'b1, 32'h10);
        check("t5_intr_clr", {31'd0, intr_l}, 32'd1);
        ack();
        irq_l = '0;
        tick();
        rd("t5_pend_1", 2'd0, 1'b1, 32'h10);
        tick();
        rd("t5_pend_2", 2'd0, 1'b1, 32'h0);
        wr(2'd3, 32'h0);
        tick();
        check("t5_intr_end", {31'd0, intr_l}, 32'd0);

        // 6: asynchronous reset while in service
        pulse(8'h04);
        ticks(3);
        ack();
        check("t6_insvc_pre", {31'd0, in_service}, 32'd1);
        #2;
        io_cs = 1'b1; io_rd = 1'b1; addr = 2'd3;
        reset = 1'b1;
        #1;
        check("t6_intr", {31'd0, intr}, 32'd0);
        check("t6_insvc", {31'd0, in_service}, 32'd0);
        check("t6_vec", {29'd0, vec_id}, 32'd0);
        check("t6_dout", d_out, 32'h0);
        io_cs = 1'b0; io_rd = 1'b0;
        #1;
        reset = 1'b0;
        rd("t6_mask", 2'd1, 1'b0, 32'h0);
        rd("t6_pend", 2'd0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
